// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: collects framed bit_en-strobed bits into WIDTH-bit words.
// Completed words go to a valid/ready output register; drops when the register is full set a sticky overrun.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sin,
  input  logic             i_bit_en,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_busy,
  output logic             o_overrun,
  input  logic             i_ovr_clr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CW-1:0]    r_bit_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;
  logic             w_capture;
  logic             w_complete;
  logic             w_accept;
  logic             w_drop;
  logic             w_load;

  generate
    if (LSB_FIRST) begin : g_lsb
      assign w_sreg_nxt = {i_sin, r_sreg[WIDTH-1:1]};
    end else begin : g_msb
      assign w_sreg_nxt = {r_sreg[WIDTH-2:0], i_sin};
    end
  endgenerate

  assign w_cnt_inc = r_bit_cnt + CW'(1);

  // A start strobe in SHIFT restarts the frame, so it can never complete a word (WIDTH >= 2).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_capture   = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bit_en && i_start) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (i_bit_en) begin
          w_capture = 1'b1;
          if (i_start) begin
            w_cnt_nxt = CW'(1);
          end else if (w_cnt_inc == LP_LAST) begin
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = r_dout_valid & i_dout_ready;
  assign w_drop   = w_complete & r_dout_valid & ~i_dout_ready;
  assign w_load   = w_complete & ~w_drop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_sreg       <= '0;
      r_bit_cnt    <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      if (w_capture) r_sreg <= w_sreg_nxt;
      // The completing word is taken straight from the shift path, giving one clock of latency.
      if (w_load) r_dout <= w_sreg_nxt;
      if (w_load)        r_dout_valid <= 1'b1;
      else if (w_accept) r_dout_valid <= 1'b0;
      if (w_drop)         r_overrun <= 1'b1;
      else if (i_ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_busy       = (r_state == SHIFT);
  assign o_overrun    = r_overrun;

endmodule
